// File: rtl/if_prefetch_unit_pkg.sv
// Shared constants and the buffered fetch record for the instruction prefetch unit.
// Defaults here seed the parameters of the interface and the top level.
package if_prefetch_unit_pkg;

  localparam int          DEF_XLEN     = 32;
  localparam int          DEF_ILEN     = 32;
  localparam int          DEF_DEPTH    = 4;
  localparam logic [63:0] DEF_RESET_PC = 64'h0;
  localparam int          DEF_PC_STEP  = 4;

  typedef struct packed {
    logic [DEF_XLEN-1:0] pc;
    logic [DEF_ILEN-1:0] inst;
  } entry_t;

  // Occupancy must represent 0..DEPTH inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/if_prefetch_unit_if.sv
// Fetch-side bundle: instruction memory port, decode handshake, redirect and occupancy.
// master = prefetch unit, slave = surrounding pipeline/memory.
interface if_prefetch_unit_if #(
  parameter int XLEN  = if_prefetch_unit_pkg::DEF_XLEN,
  parameter int ILEN  = if_prefetch_unit_pkg::DEF_ILEN,
  parameter int DEPTH = if_prefetch_unit_pkg::DEF_DEPTH
) ();
  import if_prefetch_unit_pkg::*;

  logic                        imem_req;
  logic [XLEN-1:0]             imem_addr;
  logic [ILEN-1:0]             imem_rdata;
  logic                        out_valid;
  logic                        out_ready;
  logic [ILEN-1:0]             out_inst;
  logic [XLEN-1:0]             out_pc;
  logic                        redirect;
  logic [XLEN-1:0]             redirect_pc;
  logic [occ_width(DEPTH)-1:0] occupancy;

  modport master (
    output imem_req, imem_addr, out_valid, out_inst, out_pc, occupancy,
    input  imem_rdata, out_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_inst, out_pc, occupancy,
    output imem_rdata, out_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/pipe_fifo.sv
// Generic synchronous FIFO, registered storage, combinational head; push-to-head latency 1 cycle.
// Push while full is dropped unless a pop frees the slot on the same edge; flush empties in one cycle.
module pipe_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_dat,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (!do_push && do_pop) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/if_prefetch_unit.sv
// Sequential instruction prefetcher: request N, data N+1, out_valid N+2; one instruction/cycle sustained.
// Requests stop once buffered + in-flight entries reach DEPTH; redirect/reset flush and drop the in-flight response.
module if_prefetch_unit #(
  parameter int              XLEN     = if_prefetch_unit_pkg::DEF_XLEN,
  parameter int              ILEN     = if_prefetch_unit_pkg::DEF_ILEN,
  parameter int              DEPTH    = if_prefetch_unit_pkg::DEF_DEPTH,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(if_prefetch_unit_pkg::DEF_RESET_PC),
  parameter int              PC_STEP  = if_prefetch_unit_pkg::DEF_PC_STEP
) (
  input logic                clk,
  input logic                reset,
  if_prefetch_unit_if.master bus
);
  import if_prefetch_unit_pkg::*;

  localparam int              CW         = occ_width(DEPTH);
  localparam logic [CW:0]     DEPTH_W    = DEPTH[CW:0];
  localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(STEP - XLEN'(1));

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } slot_t;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic            req;
  logic            kill;
  logic            push;
  logic            pop;
  logic            fifo_empty;
  logic [CW-1:0]   occ;
  logic [CW:0]     reserved;
  slot_t           push_slot;
  slot_t           head_slot;

  // An in-flight request already owns a buffer slot, so it counts against DEPTH.
  assign reserved = {1'b0, occ} + {{CW{1'b0}}, inflight};
  assign kill     = reset || bus.redirect;
  assign req      = !kill && (reserved < DEPTH_W);

  // The response landing in a redirect/reset cycle belongs to the abandoned stream.
  assign push      = inflight && !kill;
  assign push_slot = '{pc: inflight_pc, inst: bus.imem_rdata};
  assign pop       = !fifo_empty && bus.out_ready;

  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_pc    = head_slot.pc;
  assign bus.out_inst  = head_slot.inst;
  assign bus.occupancy = occ;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else if (bus.redirect) begin
      fetch_pc <= bus.redirect_pc & ALIGN_MASK;
      inflight <= 1'b0;
    end else begin
      inflight <= req;
      if (req) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + STEP;
      end
    end
  end

  pipe_fifo #(
    .WIDTH ($bits(slot_t)),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .flush    (bus.redirect),
    .push     (push),
    .push_dat (push_slot),
    .pop      (pop),
    .head_dat (head_slot),
    .empty    (fifo_empty),
    .count    (occ)
  );

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench: DEPTH 4/2/8 instances share stimulus; a queue model checks every cycle,
// and literal expectations on the DEPTH=4 instance pin the model.
module tb_if_prefetch_unit;
  import if_prefetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        out_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  int vectors     = 0;
  int miscompares = 0;

  logic        e_req   [3];
  logic        e_valid [3];
  logic [31:0] e_addr  [3];
  logic [31:0] e_inst  [3];
  logic [31:0] e_pc    [3];
  logic [3:0]  e_occ   [3];

  entry_t      mq    [3][$];
  bit          mif   [3];
  logic [31:0] mifpc [3];
  logic [31:0] mpc   [3];

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic int dep_of(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 2 : 8);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int D = (g == 0) ? 4 : ((g == 1) ? 2 : 8);
    logic        pend      = 1'b0;
    logic [31:0] pend_addr = '0;

    if_prefetch_unit_if #(.XLEN(32), .ILEN(32), .DEPTH(D)) bus ();

    if_prefetch_unit #(
      .XLEN(32), .ILEN(32), .DEPTH(D), .RESET_PC(32'h0), .PC_STEP(4)
    ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );

    assign bus.out_ready   = out_ready;
    assign bus.redirect    = redirect;
    assign bus.redirect_pc = redirect_pc;

    // Memory: answers a request with an address-derived word one cycle later.
    always @(negedge clk) begin
      pend      = bus.imem_req;
      pend_addr = bus.imem_addr;
    end
    always @(posedge clk) begin
      #1;
      bus.imem_rdata = pend ? pat(pend_addr) : 32'hBAD0_BAD0;
    end

    assign e_req[g]   = bus.imem_req;
    assign e_valid[g] = bus.out_valid;
    assign e_addr[g]  = bus.imem_addr;
    assign e_inst[g]  = bus.out_inst;
    assign e_pc[g]    = bus.out_pc;
    assign e_occ[g]   = 4'(bus.occupancy);
  end

  function automatic void chk(input string name, input int k,
                              input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s depth=%0d t=%0t: got %h, want %h", name, dep_of(k), $time, act, exp);
    end
  endfunction

  // Model: a list of buffered {pc,inst}, an optional outstanding request, a next fetch address.
  function automatic void model_cycle(input int k);
    int  n;
    bit  exp_req;
    bit  exp_valid;
    n         = mq[k].size();
    exp_valid = (n != 0);
    exp_req   = !reset && !redirect && ((n + (mif[k] ? 1 : 0)) < dep_of(k));
    chk("m_occupancy", k, e_occ[k], n);
    chk("m_out_valid", k, e_valid[k], exp_valid);
    chk("m_imem_req", k, e_req[k], exp_req);
    if (exp_req) chk("m_imem_addr", k, e_addr[k], mpc[k]);
    if (exp_valid) begin
      chk("m_out_pc", k, e_pc[k], mq[k][0].pc);
      chk("m_out_inst", k, e_inst[k], mq[k][0].inst);
    end
    if (reset) begin
      mq[k].delete();
      mif[k] = 1'b0;
      mpc[k] = 32'h0;
    end else if (redirect) begin
      mq[k].delete();
      mif[k] = 1'b0;
      mpc[k] = redirect_pc & ~32'h3;
    end else begin
      if (exp_valid && out_ready) void'(mq[k].pop_front());
      if (mif[k]) mq[k].push_back('{pc: mifpc[k], inst: pat(mifpc[k])});
      mif[k] = exp_req;
      if (exp_req) begin
        mifpc[k] = mpc[k];
        mpc[k]   = mpc[k] + 32'h4;
      end
    end
  endfunction

  task automatic sample();
    @(negedge clk);
    for (int k = 0; k < 3; k++) model_cycle(k);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    adv();
  endtask

  initial begin
    reset       = 1'b1;
    out_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    for (int k = 0; k < 3; k++) begin
      mq[k].delete();
      mif[k]   = 1'b0;
      mifpc[k] = 32'h0;
      mpc[k]   = 32'h0;
    end
    repeat (2) @(posedge clk);
    #1;

    sample();
    chk("rst_req", 0, e_req[0], 0);
    chk("rst_valid", 0, e_valid[0], 0);
    chk("rst_occ", 0, e_occ[0], 0);
    adv();

    // Release with decode stalled: latency, then saturation.
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sample();
      if (i == 0) begin
        chk("first_req", 0, e_req[0], 1);
        chk("first_addr", 0, e_addr[0], 32'h0);
      end
      if (i == 1) chk("lat_valid_n1", 0, e_valid[0], 0);
      if (i == 2) begin
        chk("lat_valid_n2", 0, e_valid[0], 1);
        chk("head_pc", 0, e_pc[0], 32'h0);
        chk("head_inst", 0, e_inst[0], 32'hC0DE_0000);
      end
      if (i == 9) begin
        chk("full_occ", 0, e_occ[0], 4);
        chk("full_req", 0, e_req[0], 0);
        chk("full_head", 0, e_pc[0], 32'h0);
      end
      adv();
    end

    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sample();
      chk("drain_valid", 0, e_valid[0], 1);
      chk("drain_pc", 0, e_pc[0], 32'(4 * i));
      adv();
    end

    // Restart at 0, then redirect while the 0x10 response is in flight.
    redirect = 1'b1; redirect_pc = 32'h0;
    step();
    redirect = 1'b0;
    for (int i = 1; i < 5; i++) step();
    sample();
    chk("pre_kill_addr", 0, e_addr[0], 32'h10);
    adv();
    redirect = 1'b1; redirect_pc = 32'h100;
    sample();
    chk("redir_noreq", 0, e_req[0], 0);
    adv();
    redirect = 1'b0;
    sample();
    chk("post_redir_valid", 0, e_valid[0], 0);
    chk("post_redir_occ", 0, e_occ[0], 0);
    chk("post_redir_addr", 0, e_addr[0], 32'h100);
    adv();
    step();
    sample();
    chk("redir_pc0", 0, e_pc[0], 32'h100);
    adv();
    sample();
    chk("redir_pc1", 0, e_pc[0], 32'h104);
    adv();

    // Misaligned target.
    redirect = 1'b1; redirect_pc = 32'h203;
    step();
    redirect = 1'b0;
    sample();
    chk("align_req", 0, e_req[0], 1);
    chk("align_addr", 0, e_addr[0], 32'h200);
    adv();
    repeat (3) step();

    // Back-to-back redirects: only the second target is fetched.
    redirect = 1'b1; redirect_pc = 32'h300;
    step();
    redirect_pc = 32'h407;
    step();
    redirect = 1'b0;
    sample();
    chk("b2b_addr", 0, e_addr[0], 32'h404);
    adv();
    step();
    sample();
    chk("b2b_pc", 0, e_pc[0], 32'h404);
    adv();
    repeat (2) step();

    // Redirect coincident with a transfer.
    redirect = 1'b1; redirect_pc = 32'h500;
    sample();
    chk("pop_redir_valid", 0, e_valid[0], 1);
    adv();
    redirect = 1'b0;
    sample();
    chk("pop_redir_occ", 0, e_occ[0], 0);
    chk("pop_redir_vld", 0, e_valid[0], 0);
    adv();

    // Intermittent decode stalls.
    for (int i = 0; i < 15; i++) begin
      out_ready = (i % 3 != 2);
      step();
    end

    // Steady streaming, then reset mid-stream.
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    reset = 1'b1;
    sample();
    chk("mid_rst_req", 0, e_req[0], 0);
    adv();
    sample();
    chk("mid_rst_occ", 0, e_occ[0], 0);
    chk("mid_rst_valid", 0, e_valid[0], 0);
    chk("mid_rst_req2", 0, e_req[0], 0);
    adv();
    reset = 1'b0;
    sample();
    chk("refetch_req", 0, e_req[0], 1);
    chk("refetch_addr", 0, e_addr[0], 32'h0);
    adv();
    step();
    sample();
    chk("refetch_pc", 0, e_pc[0], 32'h0);
    adv();
    repeat (6) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
